fwrisc_regfile_ctrl: RTL and testbench

Sequencing and arbitration front-end for the 64-entry x 32-bit, 2-read/1-write core register file. Out of reset it scrubs every entry to zero, since the FPGA block-RAM build has no reset. It then shares the single write port between the execute and load writeback paths with round-robin arbitration. It sits between the core pipeline and the register file and drives the register file's `rd_*` and `ra_raddr` inputs.

---
 rtl/fwrisc_regfile_ctrl.sv | 139 +++++++++++++
 tb/tb_fwrisc_regfile_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_regfile_ctrl.sv
// Register-file front end: zero-scrubs all 64 entries after reset, then round-robin arbitrates the write port.
// Optional debug access port is enabled with `define FWRISC_REGFILE_DBG_EN.
module fwrisc_regfile_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  core_ra_raddr,
    input  logic        core_ra_en,
    output logic [5:0]  ra_raddr,
    input  logic [31:0] ra_rdata,
    input  logic        ex_wvalid,
    input  logic [5:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    output logic        ex_wready,
    input  logic        ld_wvalid,
    input  logic [5:0]  ld_waddr,
    input  logic [31:0] ld_wdata,
    output logic        ld_wready,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        rd_wen,
`ifdef FWRISC_REGFILE_DBG_EN
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [5:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
`endif
    output logic        init_busy
);

    typedef enum logic {SCRUB, RUN} state_e;
    typedef enum logic {LG_EX, LG_LD} lg_e;

    state_e     state_q, state_d;
    logic [5:0] scrub_addr_q, scrub_addr_d;
    lg_e        lg_q, lg_d;
    logic       gnt_ex, gnt_ld;

`ifdef FWRISC_REGFILE_DBG_EN
    logic        ack_q, ack_d;
    logic        ack_rd_q, ack_rd_d;
    logic [31:0] dbg_rdata_q;
    logic        dbg_wr_acc, dbg_rd_acc;
`else
    logic        unused_ra_rdata;
    assign unused_ra_rdata = ^ra_rdata;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= SCRUB;
            scrub_addr_q <= 6'd0;
            lg_q         <= LG_LD;
`ifdef FWRISC_REGFILE_DBG_EN
            ack_q        <= 1'b0;
            ack_rd_q     <= 1'b0;
            dbg_rdata_q  <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            scrub_addr_q <= scrub_addr_d;
            lg_q         <= lg_d;
`ifdef FWRISC_REGFILE_DBG_EN
            ack_q        <= ack_d;
            ack_rd_q     <= ack_rd_d;
            dbg_rdata_q  <= dbg_rdata;
`endif
        end
    end

    // A tie goes to whichever requester was not granted last.
    assign gnt_ex = ex_wvalid & (~ld_wvalid | (lg_q == LG_LD));
    assign gnt_ld = ld_wvalid & ~gnt_ex;

`ifdef FWRISC_REGFILE_DBG_EN
    // Debug only uses the write port when both core paths are idle.
    assign dbg_wr_acc = ~reset & (state_q == RUN) & dbg_req & dbg_we
                        & ~ex_wvalid & ~ld_wvalid & ~ack_q;
    assign dbg_rd_acc = ~reset & (state_q == RUN) & dbg_req & ~dbg_we
                        & ~core_ra_en & ~ack_q;
    assign dbg_ack    = ack_q & ~reset;
    // Read data arrives in the ack cycle; pass it straight through, then hold it.
    assign dbg_rdata  = (ack_q & ack_rd_q & ~reset) ? ra_rdata : dbg_rdata_q;
`endif

    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr_q;
        lg_d         = lg_q;
        rd_wen       = 1'b0;
        rd_waddr     = 6'd0;
        rd_wdata     = 32'd0;
        ex_wready    = 1'b0;
        ld_wready    = 1'b0;
        init_busy    = 1'b1;
        ra_raddr     = core_ra_raddr;
`ifdef FWRISC_REGFILE_DBG_EN
        ack_d        = dbg_wr_acc | dbg_rd_acc;
        ack_rd_d     = dbg_rd_acc;
        if (dbg_rd_acc) ra_raddr = dbg_addr;
`endif
        if (!reset) begin
            case (state_q)
                SCRUB: begin
                    rd_wen       = 1'b1;
                    rd_waddr     = scrub_addr_q;
                    scrub_addr_d = scrub_addr_q + 6'd1;
                    if (scrub_addr_q == 6'd63) state_d = RUN;
                end
                RUN: begin
                    init_busy = 1'b0;
                    if (gnt_ex) begin
                        ex_wready = 1'b1;
                        rd_waddr  = ex_waddr;
                        rd_wdata  = ex_wdata;
                        rd_wen    = |ex_waddr;
                        lg_d      = LG_EX;
                    end else if (gnt_ld) begin
                        ld_wready = 1'b1;
                        rd_waddr  = ld_waddr;
                        rd_wdata  = ld_wdata;
                        rd_wen    = |ld_waddr;
                        lg_d      = LG_LD;
                    end
`ifdef FWRISC_REGFILE_DBG_EN
                    else if (dbg_wr_acc) begin
                        rd_waddr = dbg_addr;
                        rd_wdata = dbg_wdata;
                        rd_wen   = |dbg_addr;
                    end
`endif
                end
                default: state_d = SCRUB;
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_regfile_ctrl.sv
// Self-checking bench for fwrisc_regfile_ctrl with a behavioural register file and write-port reference model.
module tb_fwrisc_regfile_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  core_ra_raddr;
    logic        core_ra_en;
    logic [5:0]  ra_raddr;
    logic [31:0] ra_rdata;
    logic        ex_wvalid, ld_wvalid;
    logic [5:0]  ex_waddr, ld_waddr;
    logic [31:0] ex_wdata, ld_wdata;
    logic        ex_wready, ld_wready;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_wen;
    logic        init_busy;
`ifdef FWRISC_REGFILE_DBG_EN
    logic        dbg_req, dbg_we, dbg_ack;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] rf [64];
    logic [31:0] mdl [64];

    always #5 clock = ~clock;

    // Environment register file: synchronous write, one-cycle read latency.
    always @(posedge clock) begin
        if (rd_wen) rf[rd_waddr] <= rd_wdata;
        ra_rdata <= rf[ra_raddr];
    end

    fwrisc_regfile_ctrl dut (
        .clock(clock), .reset(reset),
        .core_ra_raddr(core_ra_raddr), .core_ra_en(core_ra_en),
        .ra_raddr(ra_raddr), .ra_rdata(ra_rdata),
        .ex_wvalid(ex_wvalid), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wready(ex_wready),
        .ld_wvalid(ld_wvalid), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata), .ld_wready(ld_wready),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
`ifdef FWRISC_REGFILE_DBG_EN
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
`endif
        .init_busy(init_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic scrub_run(input int n);
        for (int k = 0; k < n; k++) begin
            #1 chk("scrub", {rd_wen, rd_waddr, rd_wdata, init_busy, ex_wready, ld_wready},
                   {1'b1, 6'(k), 32'h0, 1'b1, 1'b0, 1'b0});
            tick();
        end
    endtask

    task automatic rd_back(input logic [5:0] a, input logic [31:0] exp, input string tag);
        core_ra_en    = 1'b1;
        core_ra_raddr = a;
        tick();
        chk(tag, ra_rdata, exp);
    endtask

    initial begin
        bit          last_ld, ex_pend, ld_pend, gex, gld, ew;
        logic [5:0]  ex_a, ld_a, ea;
        logic [31:0] ex_d, ld_d, ed;

        reset = 1'b1; core_ra_en = 1'b1; core_ra_raddr = 6'd13;
        ex_wvalid = 1'b0; ld_wvalid = 1'b0;
        ex_waddr = 6'd0; ld_waddr = 6'd0; ex_wdata = 32'd0; ld_wdata = 32'd0;
`ifdef FWRISC_REGFILE_DBG_EN
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 6'd0; dbg_wdata = 32'd0;
`endif
        for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
        repeat (3) @(posedge clock);
        tick();
        chk("rst_vals", {init_busy, rd_wen, ex_wready, ld_wready, rd_waddr, rd_wdata, ra_raddr},
            {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 6'd13});
`ifdef FWRISC_REGFILE_DBG_EN
        chk("rst_dbg", {dbg_ack, dbg_rdata}, {1'b0, 32'd0});
`endif

        // Scrub with both writers requesting: neither may be accepted.
        reset = 1'b0;
        ex_wvalid = 1'b1; ex_waddr = 6'd7; ex_wdata = 32'h77;
        ld_wvalid = 1'b1; ld_waddr = 6'd8; ld_wdata = 32'h88;
        scrub_run(64);
        ex_wvalid = 1'b0; ld_wvalid = 1'b0;
        #1 chk("busy_fall", {init_busy, rd_wen, rd_waddr, rd_wdata}, 40'd0);
        rd_back(6'd17, 32'd0, "rd_x17");

        ex_wvalid = 1'b1; ex_waddr = 6'd5; ex_wdata = 32'hDEADBEEF;
        #1 chk("ex_single", {ex_wready, ld_wready, rd_wen, rd_waddr, rd_wdata},
               {1'b1, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF});
        tick();
        ex_wvalid = 1'b0; mdl[5] = 32'hDEADBEEF;
        rd_back(6'd5, 32'hDEADBEEF, "rd_x5");

        ld_wvalid = 1'b1; ld_waddr = 6'd0; ld_wdata = 32'hFFFFFFFF;
        #1 chk("ld_x0", {ld_wready, ex_wready, rd_wen}, {1'b1, 1'b0, 1'b0});
        tick();
        ld_wvalid = 1'b0;
        rd_back(6'd0, 32'd0, "rd_x0");

        // Last grant was LD, so the tie sequence starts with EX.
        ex_wvalid = 1'b1; ex_waddr = 6'd3; ex_wdata = 32'h11;
        ld_wvalid = 1'b1; ld_waddr = 6'd4; ld_wdata = 32'h22;
        for (int i = 0; i < 4; i++) begin
            bit e;
            e = (i % 2 == 0);
            #1 chk("contend", {ex_wready, ld_wready, rd_wen, rd_waddr, rd_wdata},
                   {e, !e, 1'b1, e ? 6'd3 : 6'd4, e ? 32'h11 : 32'h22});
            tick();
        end
        ex_wvalid = 1'b0; ld_wvalid = 1'b0;
        mdl[3] = 32'h11; mdl[4] = 32'h22;
        last_ld = 1'b1;

        ex_pend = 1'b0; ld_pend = 1'b0;
        ex_a = 6'd0; ld_a = 6'd0; ex_d = 32'd0; ld_d = 32'd0;
        for (int c = 0; c < 300; c++) begin
            if (!ex_pend && $urandom_range(0, 2) != 0) begin
                ex_pend = 1'b1; ex_a = 6'($urandom_range(0, 63)); ex_d = $urandom;
            end
            if (!ld_pend && $urandom_range(0, 2) != 0) begin
                ld_pend = 1'b1; ld_a = 6'($urandom_range(0, 63)); ld_d = $urandom;
            end
            ex_wvalid = ex_pend; ex_waddr = ex_a; ex_wdata = ex_d;
            ld_wvalid = ld_pend; ld_waddr = ld_a; ld_wdata = ld_d;
            gex = ex_pend && (!ld_pend || last_ld);
            gld = ld_pend && !gex;
            ea  = gex ? ex_a : (gld ? ld_a : 6'd0);
            ed  = gex ? ex_d : (gld ? ld_d : 32'd0);
            ew  = (gex || gld) && (ea != 6'd0);
            #1 chk("rand", {ex_wready, ld_wready, rd_wen, rd_waddr, rd_wdata}, {gex, gld, ew, ea, ed});
            if (ew) mdl[ea] = ed;
            if (gex) begin last_ld = 1'b0; ex_pend = 1'b0; end
            if (gld) begin last_ld = 1'b1; ld_pend = 1'b0; end
            tick();
        end
        ex_wvalid = 1'b0; ld_wvalid = 1'b0;
        for (int i = 0; i < 64; i++) rd_back(6'(i), mdl[i], "rand_rb");

        // Reset in the middle of a scrub restarts it from address 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        scrub_run(30);
        #1 chk("mid_addr", rd_waddr, 6'd30);
        reset = 1'b1;
        tick();
        chk("mid_rst", {rd_wen, init_busy}, {1'b0, 1'b1});
        reset = 1'b0;
        scrub_run(64);
        #1 chk("busy_fall2", init_busy, 1'b0);
        ex_wvalid = 1'b1; ex_waddr = 6'd1; ex_wdata = 32'h5A5A0001;
        ld_wvalid = 1'b1; ld_waddr = 6'd2; ld_wdata = 32'h5A5A0002;
        #1 chk("lg_reset", {ex_wready, ld_wready}, {1'b1, 1'b0});
        tick();
        ex_wvalid = 1'b0; ld_wvalid = 1'b0;

`ifdef FWRISC_REGFILE_DBG_EN
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'hCAFE;
        #1 chk("dbg_wr", {rd_wen, rd_waddr, rd_wdata, dbg_ack}, {1'b1, 6'd9, 32'hCAFE, 1'b0});
        tick();
        chk("dbg_wack", {dbg_ack, rd_wen}, {1'b1, 1'b0});
        dbg_req = 1'b0;
        tick();
        chk("dbg_wack_end", dbg_ack, 1'b0);

        core_ra_en = 1'b0; core_ra_raddr = 6'd2;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd9;
        #1 chk("dbg_raddr", ra_raddr, 6'd9);
        tick();
        chk("dbg_rack", {dbg_ack, dbg_rdata}, {1'b1, 32'hCAFE});
        dbg_req = 1'b0;
        tick();
        chk("dbg_rhold", {dbg_ack, dbg_rdata}, {1'b0, 32'hCAFE});

        core_ra_en = 1'b1; core_ra_raddr = 6'd2;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("dbg_held", {dbg_ack, ra_raddr}, {1'b0, 6'd2});
            tick();
        end
        core_ra_en = 1'b0;
        #1 chk("dbg_rel", ra_raddr, 6'd1);
        tick();
        chk("dbg_rack2", {dbg_ack, dbg_rdata}, {1'b1, 32'h5A5A0001});
        dbg_req = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
